// File: rtl/reg_alu_if.sv
// Instruction issue and result bus between the issuing stage and reg_alu_pipe.
// master drives instructions, slave (the execute block) returns results.
interface reg_alu_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  in_valid;
  logic                  RegWrite;
  logic [2:0]            ALUctrl;
  logic                  ALUsrc;
  logic [ADDR_WIDTH-1:0] rs1;
  logic [ADDR_WIDTH-1:0] rs2;
  logic [ADDR_WIDTH-1:0] rd;
  logic [DATA_WIDTH-1:0] ImmOp;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] ALUout;
  logic                  EQ;
  logic [DATA_WIDTH-1:0] a0;

  modport master (
    output in_valid, RegWrite, ALUctrl, ALUsrc, rs1, rs2, rd, ImmOp,
    input  out_valid, ALUout, EQ, a0
  );

  modport slave (
    input  in_valid, RegWrite, ALUctrl, ALUsrc, rs1, rs2, rd, ImmOp,
    output out_valid, ALUout, EQ, a0
  );
endinterface

// File: rtl/reg_alu_pipe.sv
// Two-stage register file + ALU execute block: stage 1 reads/latches operands,
// stage 2 computes, writes back and registers the result; stage 2 bypasses into stage 1.
module reg_alu_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int A0_INDEX   = 10
) (
  input logic      clk,
  input logic      rst,
  reg_alu_if.slave bus
);
  localparam int NREG = 2**ADDR_WIDTH;
  localparam int SHW  = $clog2(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] A0_ADDR = ADDR_WIDTH'(A0_INDEX);

  logic [DATA_WIDTH-1:0] regs [NREG];

  logic                  s2_v;
  logic                  s2_we;
  logic [2:0]            s2_op;
  logic [ADDR_WIDTH-1:0] s2_rd;
  logic [DATA_WIDTH-1:0] s2_a;
  logic [DATA_WIDTH-1:0] s2_b;

  logic [DATA_WIDTH-1:0] alu_res;
  logic [SHW-1:0]        shamt;
  logic                  s2_wr;
  logic                  byp1;
  logic                  byp2;
  logic [DATA_WIDTH-1:0] rd1;
  logic [DATA_WIDTH-1:0] rd2;
  logic [DATA_WIDTH-1:0] opa;
  logic [DATA_WIDTH-1:0] opb;

  assign shamt = s2_b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    unique case (s2_op)
      3'b000: alu_res = s2_a + s2_b;
      3'b001: alu_res = s2_a - s2_b;
      3'b010: alu_res = s2_a & s2_b;
      3'b011: alu_res = s2_a | s2_b;
      3'b100: alu_res = s2_a ^ s2_b;
      3'b101: alu_res = s2_a << shamt;
      3'b110: alu_res = s2_a >> shamt;
      3'b111: alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(s2_a) < $signed(s2_b))};
    endcase
  end

  // Stage 2 result forwarded into stage 1 covers the same-edge write, so the
  // register file itself needs no write-first path.
  assign s2_wr = s2_v && s2_we && (s2_rd != '0);
  assign byp1  = s2_wr && (s2_rd == bus.rs1);
  assign byp2  = s2_wr && (s2_rd == bus.rs2);
  assign rd1   = (bus.rs1 == '0) ? '0 : regs[bus.rs1];
  assign rd2   = (bus.rs2 == '0) ? '0 : regs[bus.rs2];
  assign opa   = byp1 ? alu_res : rd1;
  assign opb   = bus.ALUsrc ? bus.ImmOp : (byp2 ? alu_res : rd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (s2_wr) begin
      regs[s2_rd] <= alu_res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v          <= 1'b0;
      s2_we         <= 1'b0;
      s2_op         <= '0;
      s2_rd         <= '0;
      s2_a          <= '0;
      s2_b          <= '0;
      bus.out_valid <= 1'b0;
      bus.ALUout    <= '0;
      bus.EQ        <= 1'b0;
    end else begin
      s2_v          <= bus.in_valid;
      bus.out_valid <= s2_v;
      if (bus.in_valid) begin
        s2_we <= bus.RegWrite;
        s2_op <= bus.ALUctrl;
        s2_rd <= bus.rd;
        s2_a  <= opa;
        s2_b  <= opb;
      end
      if (s2_v) begin
        bus.ALUout <= alu_res;
        bus.EQ     <= (s2_a == s2_b);
      end
    end
  end

  assign bus.a0 = regs[A0_ADDR];
endmodule

// File: tb/tb_reg_alu_pipe.sv
// Randomized + directed bench for reg_alu_pipe against an in-order architectural model.
module tb_reg_alu_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  reg_alu_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();
  reg_alu_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) bus16 ();

  reg_alu_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .A0_INDEX(10)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  reg_alu_pipe #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .A0_INDEX(2)) dut16 (
    .clk(clk), .rst(rst), .bus(bus16)
  );

  // Architectural model: instructions execute in issue order; the pipeline only
  // decides when results become visible.
  logic [31:0] mregs [32];
  logic        p_v, p_we, p_eq;
  logic [4:0]  p_rd;
  logic [31:0] p_res;
  logic        e_ov, e_eq;
  logic [31:0] e_alu;

  function automatic logic [31:0] alu_ref(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << sh;
      3'd6: return a >> sh;
      default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic cycle();
    logic [31:0] a, b;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) mregs[i] = '0;
      p_v = 1'b0; e_ov = 1'b0; e_alu = '0; e_eq = 1'b0;
    end else begin
      e_ov = p_v;
      if (p_v) begin
        e_alu = p_res;
        e_eq  = p_eq;
        if (p_we && p_rd != 5'd0) mregs[p_rd] = p_res;
      end
      p_v = bus.in_valid;
      if (bus.in_valid) begin
        a     = mregs[bus.rs1];
        b     = bus.ALUsrc ? bus.ImmOp : mregs[bus.rs2];
        p_res = alu_ref(bus.ALUctrl, a, b);
        p_eq  = (a == b);
        p_rd  = bus.rd;
        p_we  = bus.RegWrite;
      end
    end
    #1;
    check("out_valid", {31'd0, bus.out_valid}, {31'd0, e_ov});
    check("ALUout", bus.ALUout, e_alu);
    check("EQ", {31'd0, bus.EQ}, {31'd0, e_eq});
    check("a0", bus.a0, mregs[10]);
  endtask

  task automatic issue(logic we, logic [2:0] op, logic src, logic [4:0] r1,
                       logic [4:0] r2, logic [4:0] d, logic [31:0] imm);
    bus.in_valid = 1'b1; bus.RegWrite = we; bus.ALUctrl = op; bus.ALUsrc = src;
    bus.rs1 = r1; bus.rs2 = r2; bus.rd = d; bus.ImmOp = imm;
    cycle();
  endtask

  task automatic idle();
    bus.in_valid = 1'b0; bus.RegWrite = 1'b0;
    cycle();
  endtask

  task automatic issue16(logic v, logic we, logic [2:0] op, logic [2:0] r1,
                         logic [2:0] d, logic [15:0] imm);
    bus16.in_valid = v; bus16.RegWrite = we; bus16.ALUctrl = op; bus16.ALUsrc = 1'b1;
    bus16.rs1 = r1; bus16.rs2 = 3'd0; bus16.rd = d; bus16.ImmOp = imm;
    cycle();
  endtask

  logic [31:0] sweep_exp [8];

  initial begin
    sweep_exp = '{32'h80000001, 32'h7FFFFFFF, 32'h0, 32'h80000001,
                  32'h80000001, 32'h0, 32'h40000000, 32'h1};
    bus.in_valid = 0; bus.RegWrite = 0; bus.ALUctrl = 0; bus.ALUsrc = 0;
    bus.rs1 = 0; bus.rs2 = 0; bus.rd = 0; bus.ImmOp = 0;
    bus16.in_valid = 0; bus16.RegWrite = 0; bus16.ALUctrl = 0; bus16.ALUsrc = 0;
    bus16.rs1 = 0; bus16.rs2 = 0; bus16.rd = 0; bus16.ImmOp = 0;
    p_v = 0; p_we = 0; p_eq = 0; p_rd = 0; p_res = 0; e_ov = 0; e_eq = 0; e_alu = 0;
    for (int i = 0; i < 32; i++) mregs[i] = '0;

    rst = 1'b1;
    idle(); idle();
    check("rst_ov", {31'd0, bus.out_valid}, 32'd0);
    check("rst_alu", bus.ALUout, 32'd0);
    check("rst_eq", {31'd0, bus.EQ}, 32'd0);
    check("rst_a0", bus.a0, 32'd0);
    check("rst_ov16", {31'd0, bus16.out_valid}, 32'd0);
    rst = 1'b0;

    // x1 <- 0+5, x10 <- x1+7
    issue(1, 3'd0, 1, 0, 0, 1, 32'd5);
    issue(1, 3'd0, 1, 1, 0, 10, 32'd7);
    check("t1_first", bus.ALUout, 32'd5);
    idle();
    check("t1_second", bus.ALUout, 32'd12);
    check("t1_a0", bus.a0, 32'd12);

    // back-to-back dependent chain on x2
    issue(1, 3'd0, 1, 0, 0, 2, 32'd3);
    issue(1, 3'd0, 0, 2, 2, 2, 32'd0);
    check("chain_3", bus.ALUout, 32'd3);
    check("chain_ov1", {31'd0, bus.out_valid}, 32'd1);
    issue(1, 3'd1, 1, 2, 0, 2, 32'd1);
    check("chain_6", bus.ALUout, 32'd6);
    check("chain_ov2", {31'd0, bus.out_valid}, 32'd1);
    idle();
    check("chain_5", bus.ALUout, 32'd5);
    check("chain_ov3", {31'd0, bus.out_valid}, 32'd1);
    idle();
    check("chain_ov_drop", {31'd0, bus.out_valid}, 32'd0);

    // write to x0 is discarded and never bypassed
    issue(1, 3'd0, 1, 0, 0, 0, 32'hFFFFFFFF);
    issue(0, 3'd0, 0, 0, 0, 5, 32'd0);
    check("x0_wr_res", bus.ALUout, 32'hFFFFFFFF);
    idle();
    check("x0_read", bus.ALUout, 32'd0);

    // opcode sweep, A=0x80000000 B=1
    issue(1, 3'd0, 1, 0, 0, 4, 32'h80000000);
    for (int op = 0; op < 8; op++) begin
      issue(0, 3'(op), 1, 4, 0, 0, 32'd1);
      idle();
      check($sformatf("sweep_op%0d", op), bus.ALUout, sweep_exp[op]);
      check($sformatf("sweep_eq%0d", op), {31'd0, bus.EQ}, 32'd0);
    end
    issue(1, 3'd0, 1, 0, 0, 6, 32'd1);
    issue(0, 3'd1, 1, 6, 0, 0, 32'd1);
    idle();
    check("eq_equal", {31'd0, bus.EQ}, 32'd1);
    check("eq_sub", bus.ALUout, 32'd0);

    // wrap-around
    issue(1, 3'd0, 1, 0, 0, 7, 32'hFFFFFFFF);
    issue(0, 3'd0, 1, 7, 0, 0, 32'd1);
    idle();
    check("wrap_add", bus.ALUout, 32'd0);
    issue(0, 3'd1, 1, 0, 0, 0, 32'd1);
    idle();
    check("wrap_sub", bus.ALUout, 32'hFFFFFFFF);
    issue(0, 3'd5, 1, 6, 0, 0, 32'd33);
    idle();
    check("sll_33", bus.ALUout, 32'd2);

    // reset mid-flight, with a competing in_valid during reset
    issue(1, 3'd0, 1, 0, 0, 3, 32'd9);
    rst = 1'b1;
    issue(1, 3'd0, 1, 0, 0, 3, 32'd9);
    check("midrst_ov", {31'd0, bus.out_valid}, 32'd0);
    rst = 1'b0;
    idle();
    check("midrst_ov2", {31'd0, bus.out_valid}, 32'd0);
    issue(0, 3'd0, 1, 3, 0, 0, 32'd0);
    idle();
    check("midrst_x3", bus.ALUout, 32'd0);
    check("midrst_a0", bus.a0, 32'd0);

    // 16-bit variant
    issue16(1, 1, 3'd0, 0, 1, 16'h7FFF);
    issue16(1, 1, 3'd0, 1, 2, 16'h0001);
    issue16(1, 0, 3'd7, 2, 0, 16'h0001);
    check("w16_add", {16'd0, bus16.ALUout}, 32'h8000);
    issue16(0, 0, 3'd0, 0, 0, 16'h0000);
    check("w16_slt", {16'd0, bus16.ALUout}, 32'd1);
    check("w16_ov", {31'd0, bus16.out_valid}, 32'd1);
    check("w16_a0", {16'd0, bus16.a0}, 32'h8000);

    // random traffic over a small register window to stress the bypass and a0
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(63) == 0);
      if ($urandom_range(3) != 0) begin
        issue(1'($urandom_range(1)), 3'($urandom_range(7)), 1'($urandom_range(1)),
              5'($urandom_range(11)), 5'($urandom_range(11)), 5'($urandom_range(11)),
              ($urandom_range(1) != 0) ? 32'($urandom_range(40)) : 32'($urandom));
      end else begin
        idle();
      end
    end
    rst = 1'b0;
    idle(); idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
